// File: rtl/encoder_pkg.sv
// encoder_pkg: shared FSM state type and parameter helpers for the encoding sequencer
package encoder_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic EU_RST_ACT_DEF = 1'b1;

    function automatic int segw(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction
endpackage

// File: rtl/seg_counter.sv
// seg_counter: modulo-N segment counter with clear, enable and terminal-count flag
module seg_counter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    assign tc_o  = cnt_q == W'(N - 1);
    assign cnt_o = cnt_q;
    always_ff @(posedge clk) begin
        cnt_q <= clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + W'(1)) : cnt_q;
    end
endmodule

// File: rtl/encoding_sequencer.sv
// encoding_sequencer: drives the rotating-circulant Encoding_Unit through one codeword per transaction
module encoding_sequencer
    import encoder_pkg::*;
#(
    parameter int   M          = 32,
    parameter int   Lm         = 16,
    parameter logic EU_RST_ACT = EU_RST_ACT_DEF
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [M-1:0]                      msg_in,
    input  logic [M-1:0]                      f_in,
    output logic [M-1:0]                      msg_M,
    output logic [M-1:0]                      f_M,
    output logic [segw(M/Lm)-1:0]             seg_sel,
    output logic                              m_en0,
    output logic                              eu_rst,
    input  logic [M-1:0]                      p_M,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [M-1:0]                      parity_out,
    output logic                              busy,
    output logic [15:0]                       cw_count
);
    localparam int NSEG = M / Lm;
    localparam int SEGW = segw(NSEG);

    state_e         state_q;
    logic [M-1:0]   msg_q, f_q, par_q;
    logic [15:0]    cnt_q;
    logic           in_ready_q, out_valid_q, busy_q, eu_rst_q;
    logic           seg_tc;

    // The counter sits at 0 everywhere but RUN, so seg_sel needs no extra gating.
    seg_counter #(.N(NSEG), .W(SEGW)) u_seg (
        .clk   (clk_in),
        .clr_i (!rst || state_q != RUN),
        .en_i  (state_q == RUN),
        .cnt_o (seg_sel),
        .tc_o  (seg_tc)
    );

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            f_q         <= '0;
            par_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            eu_rst_q    <= EU_RST_ACT;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    msg_q      <= msg_in;
                    f_q        <= f_in;
                    state_q    <= CLEAR;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                CLEAR: begin
                    state_q  <= RUN;
                    eu_rst_q <= ~EU_RST_ACT;
                end
                RUN: if (seg_tc) begin
                    state_q  <= CAPT;
                    eu_rst_q <= EU_RST_ACT;
                end
                CAPT: begin
                    par_q       <= p_M;
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    cnt_q       <= cnt_q + 16'd1;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    eu_rst_q    <= EU_RST_ACT;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign eu_rst     = eu_rst_q;
    assign msg_M      = msg_q;
    assign f_M        = f_q;
    assign parity_out = par_q;
    assign cw_count   = cnt_q;
    assign m_en0      = seg_sel[0];
endmodule
